// File: rtl/rename_regfile_mp.sv
// Architectural register file with rename tags and multi-port commit.
// Provides combinational reads with commit/rename forwarding.
//
// Ports:
//   clk, rst                 clock, sync active-high reset
//   rdy                      global ready (hold state when low)
//   clear                    flush: drop all tags, keep data
//   rd_pos/rd_data/rd_tag    NRP pairs of {rs2,rs1} read ports
//   ren_en/ren_pos/ren_tag   one destination rename per pair
//   cm_en/cm_pos/cm_data/cm_tag  NCP ROB commit ports
//   busy_cnt                 count of registers with non-empty tag
module rename_regfile_mp #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int TW   = 4,
    parameter int NRP  = 2,
    parameter int NCP  = 2,
    localparam int RW  = $clog2(NREG),
    localparam int CW  = $clog2(NREG) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               clear,
    input  logic [NRP*2*RW-1:0] rd_pos,
    output logic [NRP*2*DW-1:0] rd_data,
    output logic [NRP*2*TW-1:0] rd_tag,
    input  logic [NRP-1:0]     ren_en,
    input  logic [NRP*RW-1:0]  ren_pos,
    input  logic [NRP*TW-1:0]  ren_tag,
    input  logic [NCP-1:0]     cm_en,
    input  logic [NCP*RW-1:0]  cm_pos,
    input  logic [NCP*DW-1:0]  cm_data,
    input  logic [NCP*TW-1:0]  cm_tag,
    output logic [CW-1:0]      busy_cnt
);

    logic [DW-1:0] data_q [NREG];
    logic [TW-1:0] tag_q  [NREG];
    logic [DW-1:0] data_n [NREG];
    logic [TW-1:0] tag_n  [NREG];
    logic [CW-1:0] cnt_n;

    // Read path: stored value, overridden by a matching commit,
    // then by renames from lower-numbered pairs (later pair wins).
    always_comb begin : rd_path
        logic [RW-1:0] idx;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        rd_data = '0;
        rd_tag  = '0;
        idx     = '0;
        d       = '0;
        t       = '0;
        for (int i = 0; i < 2*NRP; i++) begin
            idx = rd_pos[i*RW +: RW];
            d   = data_q[idx];
            t   = tag_q[idx];
            for (int c = 0; c < NCP; c++) begin
                if (cm_en[c] && cm_pos[c*RW +: RW] == idx &&
                    cm_tag[c*TW +: TW] == tag_q[idx]) begin
                    d = cm_data[c*DW +: DW];
                    t = '0;
                end
            end
            for (int j = 0; j < i/2; j++) begin
                if (ren_en[j] && ren_pos[j*RW +: RW] == idx)
                    t = ren_tag[j*TW +: TW];
            end
            if (idx == '0) begin
                d = '0;
                t = '0;
            end
            rd_data[i*DW +: DW] = d;
            rd_tag[i*TW +: TW]  = t;
        end
    end

    // Next state: commits first (higher port wins), then renames
    // (higher pair wins) unless flushing.
    always_comb begin : nxt_path
        logic [RW-1:0] p;
        p = '0;
        for (int r = 0; r < NREG; r++) begin
            data_n[r] = data_q[r];
            tag_n[r]  = tag_q[r];
        end
        for (int c = 0; c < NCP; c++) begin
            p = cm_pos[c*RW +: RW];
            if (cm_en[c] && cm_tag[c*TW +: TW] == tag_q[p]) begin
                data_n[p] = cm_data[c*DW +: DW];
                tag_n[p]  = '0;
            end
        end
        if (clear) begin
            for (int r = 0; r < NREG; r++)
                tag_n[r] = '0;
        end else begin
            for (int j = 0; j < NRP; j++) begin
                p = ren_pos[j*RW +: RW];
                if (ren_en[j])
                    tag_n[p] = ren_tag[j*TW +: TW];
            end
        end
        // x0 is hardwired zero whatever was written above
        data_n[0] = '0;
        tag_n[0]  = '0;
        cnt_n = '0;
        for (int r = 1; r < NREG; r++)
            cnt_n = cnt_n + CW'(tag_n[r] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_cnt <= '0;
        end else if (clear || rdy) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= data_n[r];
                tag_q[r]  <= tag_n[r];
            end
            busy_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Testbench for rename_regfile_mp: directed stimulus with a
// scoreboard queue checked by a separate negedge monitor.
module tb_rename_regfile_mp;

    localparam int NREG = 32;
    localparam int DW   = 32;
    localparam int TW   = 4;
    localparam int NRP  = 2;
    localparam int NCP  = 2;
    localparam int RW   = 5;
    localparam int CW   = 6;

    logic                clk;
    logic                rst;
    logic                rdy;
    logic                clear;
    logic [NRP*2*RW-1:0] rd_pos;
    logic [NRP*2*DW-1:0] rd_data;
    logic [NRP*2*TW-1:0] rd_tag;
    logic [NRP-1:0]      ren_en;
    logic [NRP*RW-1:0]   ren_pos;
    logic [NRP*TW-1:0]   ren_tag;
    logic [NCP-1:0]      cm_en;
    logic [NCP*RW-1:0]   cm_pos;
    logic [NCP*DW-1:0]   cm_data;
    logic [NCP*TW-1:0]   cm_tag;
    logic [CW-1:0]       busy_cnt;

    rename_regfile_mp #(
        .NREG(NREG), .DW(DW), .TW(TW), .NRP(NRP), .NCP(NCP)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .rd_pos(rd_pos), .rd_data(rd_data), .rd_tag(rd_tag),
        .ren_en(ren_en), .ren_pos(ren_pos), .ren_tag(ren_tag),
        .cm_en(cm_en), .cm_pos(cm_pos), .cm_data(cm_data),
        .cm_tag(cm_tag), .busy_cnt(busy_cnt)
    );

    typedef struct {
        int          cyc;
        string       nm;
        int          kind;
        int          port;
        logic [31:0] d;
        logic [3:0]  t;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   pass_cnt;
    int   fail_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                fail_cnt++;
                $display("FAIL %s: check missed (cycle %0d)", e.nm, e.cyc);
            end else if (e.kind == 0) begin
                if (rd_data[e.port*DW +: DW] === e.d &&
                    rd_tag[e.port*TW +: TW] === e.t) begin
                    pass_cnt++;
                end else begin
                    fail_cnt++;
                    $display("FAIL %s: got data=%h tag=%0d, want data=%h tag=%0d",
                             e.nm, rd_data[e.port*DW +: DW],
                             rd_tag[e.port*TW +: TW], e.d, e.t);
                end
            end else begin
                if (busy_cnt === CW'(e.cnt)) begin
                    pass_cnt++;
                end else begin
                    fail_cnt++;
                    $display("FAIL %s: got busy_cnt=%0d, want %0d",
                             e.nm, busy_cnt, e.cnt);
                end
            end
        end
    end

    task automatic exp_rd(input string nm, input int p,
                          input logic [31:0] d, input int t);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.kind = 0; e.port = p;
        e.d = d; e.t = 4'(t); e.cnt = 0;
        sb.push_back(e);
    endtask

    task automatic exp_cnt(input string nm, input int n);
        exp_t e;
        e.cyc = cyc; e.nm = nm; e.kind = 1; e.port = 0;
        e.d = '0; e.t = '0; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic rd(input int p, input int idx);
        rd_pos[p*RW +: RW] = RW'(idx);
    endtask

    task automatic ren(input int j, input int pos, input int tg);
        ren_en[j] = 1'b1;
        ren_pos[j*RW +: RW] = RW'(pos);
        ren_tag[j*TW +: TW] = TW'(tg);
    endtask

    task automatic cm(input int c, input int pos, input int tg,
                      input logic [31:0] d);
        cm_en[c] = 1'b1;
        cm_pos[c*RW +: RW] = RW'(pos);
        cm_tag[c*TW +: TW] = TW'(tg);
        cm_data[c*DW +: DW] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        rd_pos = '0;
        ren_en = '0; ren_pos = '0; ren_tag = '0;
        cm_en = '0; cm_pos = '0; cm_data = '0; cm_tag = '0;
    endtask

    initial begin
        pass_cnt = 0;
        fail_cnt = 0;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        rd_pos = '0;
        ren_en = '0; ren_pos = '0; ren_tag = '0;
        cm_en = '0; cm_pos = '0; cm_data = '0; cm_tag = '0;
        @(posedge clk);
        nxt();
        // T1: reset state; rename x5/3, pair1 sees it forwarded
        exp_cnt("rst_cnt", 0);
        rd(0, 5); exp_rd("rst_x5", 0, 32'h0, 0);
        rd(1, 0); exp_rd("rst_x0", 1, 32'h0, 0);
        ren(0, 5, 3);
        rd(2, 5); exp_rd("fwd_ren_x5", 2, 32'h0, 3);
        nxt();
        // T2: commit x5/3 DEAD, forwarded same cycle
        exp_cnt("cnt_after_ren", 1);
        cm(0, 5, 3, 32'hDEAD);
        rd(0, 5); exp_rd("fwd_cm_x5", 0, 32'hDEAD, 0);
        nxt();
        // T3: two renames of x5, higher pair wins
        exp_cnt("cnt_after_cm", 0);
        rd(0, 5); exp_rd("x5_committed", 0, 32'hDEAD, 0);
        ren(0, 5, 2); ren(1, 5, 3);
        nxt();
        // T4: re-rename x5 to 7, pair1 forwarded
        exp_cnt("cnt_dual_ren", 1);
        rd(0, 5); exp_rd("dual_ren_win", 0, 32'hDEAD, 3);
        ren(0, 5, 7);
        rd(2, 5); exp_rd("fwd_ren7", 2, 32'hDEAD, 7);
        nxt();
        // T5: stale commit x5/3 must be ignored
        cm(0, 5, 3, 32'h11);
        rd(0, 5); exp_rd("stale_cm_nofwd", 0, 32'hDEAD, 7);
        nxt();
        // T6: stale commit had no effect; rename x6/2
        exp_cnt("cnt_stale", 1);
        rd(0, 5); exp_rd("stale_cm_x5", 0, 32'hDEAD, 7);
        ren(1, 6, 2);
        nxt();
        // T7: commit x6/2 and x5/7 with same-cycle reads
        exp_cnt("cnt_two_busy", 2);
        cm(1, 6, 2, 32'h42); cm(0, 5, 7, 32'h77);
        rd(1, 6); exp_rd("fwd_cm_x6", 1, 32'h42, 0);
        rd(0, 5); exp_rd("fwd_cm_x5b", 0, 32'h77, 0);
        nxt();
        // T8: rename x8/5
        exp_cnt("cnt_drained", 0);
        ren(0, 8, 5);
        nxt();
        // T9: dual commit to x8 plus rename to x8
        cm(0, 8, 5, 32'hA); cm(1, 8, 5, 32'hB);
        ren(1, 8, 9);
        rd(0, 8); exp_rd("dual_cm_fwd", 0, 32'hB, 0);
        nxt();
        // T10: rdy low -> hold
        exp_cnt("cnt_cm_ren", 1);
        rd(0, 8); exp_rd("cm_then_ren", 0, 32'hB, 9);
        nxt();
        rdy = 1'b0;
        ren(0, 9, 1); cm(0, 8, 9, 32'hC);
        rd(1, 5); exp_rd("rdy0_read", 1, 32'h77, 0);
        nxt();
        // T11: state held; pair0 renames x7/4, pair1 reads x7
        exp_cnt("cnt_rdy_hold", 1);
        rd(1, 8); exp_rd("rdy_hold_x8", 1, 32'hB, 9);
        rd(3, 9); exp_rd("rdy_hold_x9", 3, 32'h0, 0);
        nxt();
        ren(0, 7, 4);
        rd(0, 7); exp_rd("pair0_x7_unaff", 0, 32'h0, 0);
        rd(2, 7); exp_rd("pair1_x7_fwd", 2, 32'h0, 4);
        nxt();
        // T12..T14: fill x3..x9
        exp_cnt("cnt_x7", 2);
        ren(0, 3, 1); ren(1, 4, 2);
        nxt();
        exp_cnt("cnt_fill1", 4);
        ren(0, 5, 3); ren(1, 6, 5);
        nxt();
        exp_cnt("cnt_fill2", 6);
        ren(0, 9, 6);
        nxt();
        // T15: clear with commit to x3, rename ignored
        exp_cnt("cnt_full", 7);
        clear = 1'b1; rdy = 1'b0;
        cm(0, 3, 1, 32'h99);
        ren(0, 10, 2);
        rd(0, 3); exp_rd("clear_fwd_x3", 0, 32'h99, 0);
        nxt();
        // T16: after clear
        exp_cnt("cnt_clear", 0);
        rd(0, 3);  exp_rd("clear_x3", 0, 32'h99, 0);
        rd(1, 5);  exp_rd("clear_x5", 1, 32'h77, 0);
        rd(2, 8);  exp_rd("clear_x8", 2, 32'hB, 0);
        rd(3, 10); exp_rd("clear_x10", 3, 32'h0, 0);
        nxt();
        // T17: rename and commit to x0
        ren(0, 0, 5); cm(1, 0, 0, 32'h55);
        rd(0, 0); exp_rd("x0_cm_fwd", 0, 32'h0, 0);
        rd(2, 0); exp_rd("x0_ren_fwd", 2, 32'h0, 0);
        nxt();
        exp_cnt("cnt_x0", 0);
        rd(0, 0); exp_rd("x0_after", 0, 32'h0, 0);
        ren(0, 12, 3);
        nxt();
        // T19: rst mid-activity
        exp_cnt("cnt_x12", 1);
        rst = 1'b1; clear = 1'b1;
        cm(0, 3, 0, 32'h1234);
        ren(0, 13, 4);
        nxt();
        // T20: everything zero again
        exp_cnt("cnt_rst2", 0);
        rd(0, 3);  exp_rd("rst2_x3", 0, 32'h0, 0);
        rd(1, 5);  exp_rd("rst2_x5", 1, 32'h0, 0);
        rd(2, 12); exp_rd("rst2_x12", 2, 32'h0, 0);
        rd(3, 13); exp_rd("rst2_x13", 3, 32'h0, 0);
        nxt();
        nxt();
        if (sb.size() != 0) begin
            fail_cnt++;
            $display("FAIL leftover: got %0d pending checks, want 0",
                     sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/rename_regfile_mp.md
RENAME_REGFILE_MP -- requirements
Module: rename_regfile_mp

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter TW, default 4, meaning rename tag width; tag value 0 means "no pending producer" (empty).
REQ-004 SHALL have parameter NRP, default 2, meaning number of decode read-port pairs (rs1/rs2 per pair).
REQ-005 SHALL have parameter NCP, default 2, meaning number of commit ports.
REQ-006 SHALL derive RW = clog2(NREG) as the register-index width.
REQ-007 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-008 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-009 SHALL have port rdy  input  1  global ready; when low, hold all state except under rst/clear.
REQ-010 SHALL have port clear  input  1  misprediction flush; drops all tags.
REQ-011 SHALL have port rd_pos  input  NRP*2*RW  read indices, packed {pair k: rs2,rs1}.
REQ-012 SHALL have ports rd_data and rd_tag  output  NRP*2*DW and NRP*2*TW  read values and tags, packed like rd_pos.
REQ-013 SHALL have ports ren_en  input  NRP, ren_pos  input  NRP*RW, and ren_tag  input  NRP*TW  destination renames, one per pair.
REQ-014 SHALL have ports cm_en  input  NCP, cm_pos  input  NCP*RW, cm_data  input  NCP*DW, and cm_tag  input  NCP*TW  ROB commits.
REQ-015 SHALL have port busy_cnt  output  clog2(NREG)+1  number of registers currently holding a non-empty tag.

Function
REQ-016 SHALL hold per-register data[DW] and tag[TW]; register 0 SHALL always read data 0 and tag 0 and SHALL ignore renames and commits.
REQ-017 SHALL produce reads combinationally with commit forwarding: rd_tag = empty and rd_data = cm_data[c] if any enabled commit c has cm_pos == index and cm_tag == stored tag; otherwise stored data and tag.
REQ-018 SHALL, for pair k, forward the rename of every lower pair j<k into pair k's reads: if ren_en[j] and ren_pos[j] == index (nonzero), rd_tag = ren_tag[j], with the highest such j winning.
REQ-019 SHALL, on commit c when tag[cm_pos] == cm_tag, write data <= cm_data and tag <= empty; on tag mismatch, write neither data nor tag.
REQ-020 SHALL resolve two matching commits to the same register in one cycle by the higher commit index winning the data write.
REQ-021 SHALL apply renames after commits in the same cycle: a rename to a register also committed that cycle sets the new tag, and the commit's data write still occurs.
REQ-022 SHALL resolve two renames to the same register in one cycle by the higher pair index winning.
REQ-023 SHALL update busy_cnt as a registered count that is exact after each edge, equal to the population of non-empty tags.
REQ-024 SHALL, on clear (rdy ignored): apply matching commits' data writes that cycle, set all tags empty, retain all data, ignore renames, and set busy_cnt to 0.
REQ-025 SHALL produce no state change when rdy is low and neither rst nor clear is asserted; reads remain valid.

Reset
REQ-026 SHALL, on rst (dominant over clear and rdy), set all data to 0, all tags to empty, and busy_cnt to 0, ignoring commits and renames that cycle.
REQ-027 SHALL begin accepting renames and commits in the first cycle after rst deasserts.

Verification
REQ-028 SHALL verify: rename x5 with tag 3, then commit x5 with tag 3 and data 0xDEAD -> rd x5 reads tag 0, data 0xDEAD; busy_cnt goes 1 -> 0.
REQ-029 SHALL verify: rename x5 with tag 3, rename x5 with tag 7, then commit x5 with tag 3 and data 0x11 -> data unchanged, tag stays 7.
REQ-030 SHALL verify: commit x6 with tag 2 and data 0x42 in the same cycle rd_pos = x6 -> combinational read gives data 0x42, tag 0.
REQ-031 SHALL verify: pair0 renames x7 with tag 4, pair1 reads x7 the same cycle -> pair1 rd_tag = 4; pair0 rd_tag unaffected.
REQ-032 SHALL verify: with x3..x9 renamed, assert clear together with a commit to x3 carrying data 0x99 -> all tags 0, x3 = 0x99, other data retained, busy_cnt = 0.
REQ-033 SHALL verify: rename and commit to x0, and rst asserted mid-activity -> x0 always reads 0 with tag 0; after rst, all data and tags are 0.
